lc3_wb_arbiter: RTL and testbench

LC3_WB_ARBITER -- requirements
Module: lc3_wb_arbiter

---
 rtl/lc3_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_lc3_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_wb_arbiter.sv
// LC-3 register-file writeback arbiter.
//
// Two requesters (execute path and memory load) compete for a single
// register-file write port. Grants are combinational and the winning write is
// registered onto rf_* one cycle later, together with the NZP condition code.
// Memory normally wins a conflict. When the optional starvation guard is
// compiled in, an execute requester that keeps losing is promoted after
// STARVE_LIMIT consecutive losses.
//
// Build option: define LC3_WB_STARVE_EN to enable the starvation guard. With
// the macro undefined, memory always wins a conflict and starve_cnt reads 0.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   enable_writeback      global enable; no grant while low
//   exe_req/dr/data       execute write request, held until granted
//   exe_gnt               combinational execute grant
//   mem_req/dr/data       memory-load write request, held until granted
//   mem_gnt               combinational memory grant
//   rf_we/rf_addr/rf_data registered register-file write port
//   psr                   registered {N,Z,P}
//   starve_cnt            consecutive execute losses (debug)
module lc3_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_writeback,
  input  logic        exe_req,
  input  logic [2:0]  exe_dr,
  input  logic [15:0] exe_data,
  output logic        exe_gnt,
  input  logic        mem_req,
  input  logic [2:0]  mem_dr,
  input  logic [15:0] mem_data,
  output logic        mem_gnt,
  output logic        rf_we,
  output logic [2:0]  rf_addr,
  output logic [15:0] rf_data,
  output logic [2:0]  psr,
  output logic [1:0]  starve_cnt
);

  typedef enum logic [0:0] {StMemPri, StExePri} state_e;

  state_e state_q;

  // Grant logic: a lone request always wins; a conflict goes to the
  // priority requester of the current state.
  always_comb begin
    exe_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (enable_writeback) begin
      if (exe_req && mem_req) begin
        if (state_q == StExePri) exe_gnt = 1'b1;
        else                     mem_gnt = 1'b1;
      end else begin
        exe_gnt = exe_req;
        mem_gnt = mem_req;
      end
    end
  end

`ifdef LC3_WB_STARVE_EN
  localparam logic [1:0] Limit = STARVE_LIMIT[1:0];

  state_e     state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       exe_lost;

  assign exe_lost = exe_req && mem_gnt && !exe_gnt;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (exe_gnt) begin
      cnt_d   = '0;
      state_d = StMemPri;
    end else if (exe_lost) begin
      if (cnt_q < Limit) cnt_d = cnt_q + 2'd1;
      // Promote on the edge at which the count reaches the limit.
      if (state_q == StMemPri && cnt_d == Limit) state_d = StExePri;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StMemPri;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign starve_cnt = cnt_q;
`else
  assign state_q    = StMemPri;
  assign starve_cnt = '0;
`endif

  // Writeback datapath.
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  wr_nzp;

  always_comb begin
    wr_addr = exe_gnt ? exe_dr   : mem_dr;
    wr_data = exe_gnt ? exe_data : mem_data;
    if (wr_data[15])           wr_nzp = 3'b100;
    else if (wr_data == '0)    wr_nzp = 3'b010;
    else                       wr_nzp = 3'b001;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      psr     <= 3'b000;
    end else if (exe_gnt || mem_gnt) begin
      rf_we   <= 1'b1;
      rf_addr <= wr_addr;
      rf_data <= wr_data;
      psr     <= wr_nzp;
    end else begin
      rf_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_wb_arbiter.sv
// Self-checking bench for lc3_wb_arbiter: directed scenarios followed by
// randomized request traffic compared against a behavioural model.
module tb_lc3_wb_arbiter;

  localparam int Limit = 3;
`ifdef LC3_WB_STARVE_EN
  localparam bit StarveEn = 1'b1;
`else
  localparam bit StarveEn = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        enable_writeback;
  logic        exe_req;
  logic [2:0]  exe_dr;
  logic [15:0] exe_data;
  logic        exe_gnt;
  logic        mem_req;
  logic [2:0]  mem_dr;
  logic [15:0] mem_data;
  logic        mem_gnt;
  logic        rf_we;
  logic [2:0]  rf_addr;
  logic [15:0] rf_data;
  logic [2:0]  psr;
  logic [1:0]  starve_cnt;

  lc3_wb_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .exe_req          (exe_req),
    .exe_dr           (exe_dr),
    .exe_data         (exe_data),
    .exe_gnt          (exe_gnt),
    .mem_req          (mem_req),
    .mem_dr           (mem_dr),
    .mem_data         (mem_data),
    .mem_gnt          (mem_gnt),
    .rf_we            (rf_we),
    .rf_addr          (rf_addr),
    .rf_data          (rf_data),
    .psr              (psr),
    .starve_cnt       (starve_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: consecutive execute losses; execute wins a conflict once it has
  // lost Limit times in a row (only with the starvation guard).
  int          m_losses;
  logic        m_we;
  logic [2:0]  m_addr;
  logic [15:0] m_data;
  logic [2:0]  m_psr;

  logic obs_exe, obs_mem;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] nzp(input logic [15:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == 16'h0000)  return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_reset();
    m_losses = 0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_psr    = 3'b000;
  endtask

  // One clock cycle: check at the falling edge, then advance the model.
  task automatic step();
    logic e_exe, e_mem;
    @(negedge clock);
    e_exe = 1'b0;
    e_mem = 1'b0;
    if (enable_writeback) begin
      if (exe_req && mem_req) begin
        if (StarveEn && m_losses >= Limit) e_exe = 1'b1;
        else                               e_mem = 1'b1;
      end else begin
        e_exe = exe_req;
        e_mem = mem_req;
      end
    end
    obs_exe = exe_gnt;
    obs_mem = mem_gnt;
    check("exe_gnt",    32'(exe_gnt),    32'(e_exe));
    check("mem_gnt",    32'(mem_gnt),    32'(e_mem));
    check("rf_we",      32'(rf_we),      32'(m_we));
    check("rf_addr",    32'(rf_addr),    32'(m_addr));
    check("rf_data",    32'(rf_data),    32'(m_data));
    check("psr",        32'(psr),        32'(m_psr));
    check("starve_cnt", 32'(starve_cnt), 32'(StarveEn ? m_losses : 0));
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      m_we = e_exe || e_mem;
      if (e_exe) begin
        m_addr = exe_dr;  m_data = exe_data;  m_psr = nzp(exe_data);
      end else if (e_mem) begin
        m_addr = mem_dr;  m_data = mem_data;  m_psr = nzp(mem_data);
      end
      if (e_exe)                       m_losses = 0;
      else if (e_mem && exe_req)       m_losses = (m_losses + 1 > Limit) ? Limit : m_losses + 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    enable_writeback = 1'b1;
    exe_req = 1'b0;  exe_dr = '0;  exe_data = '0;
    mem_req = 1'b0;  mem_dr = '0;  mem_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'h8000 | 16'($urandom_range(0, 16'h7fff));
      default: return 16'($urandom_range(0, 16'hffff));
    endcase
  endfunction

  int exp_exe[6];
  int exp_cnt[6];

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;

    // Idle after reset.
    step();
    check("idle_we", 32'(rf_we), 32'd0);
    check("idle_psr", 32'(psr), 32'd0);

    // Lone execute request with a negative value.
    exe_req = 1'b1;  exe_dr = 3'd3;  exe_data = 16'h8001;
    step();
    check("exe_alone_gnt", 32'(obs_exe), 32'd1);
    exe_req = 1'b0;
    check("exe_alone_we",   32'(rf_we),   32'd1);
    check("exe_alone_addr", 32'(rf_addr), 32'd3);
    check("exe_alone_data", 32'(rf_data), 32'h8001);
    check("exe_alone_psr",  32'(psr),     32'b100);
    step();

    // Both requests held for six cycles; memory re-presents after each grant.
    if (StarveEn) begin
      exp_exe = '{0, 0, 0, 1, 0, 0};
      exp_cnt = '{1, 2, 3, 0, 1, 2};
    end else begin
      exp_exe = '{0, 0, 0, 0, 0, 0};
      exp_cnt = '{0, 0, 0, 0, 0, 0};
    end
    do_reset();
    exe_req = 1'b1;  exe_dr = 3'd5;  exe_data = 16'h0042;
    mem_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_dr   = 3'(i);
      mem_data = 16'h1000 + 16'(i);
      step();
      check("conflict_exe", 32'(obs_exe), 32'(exp_exe[i]));
      check("conflict_mem", 32'(obs_mem), 32'(1 - exp_exe[i]));
      check("conflict_cnt", 32'(starve_cnt), 32'(exp_cnt[i]));
    end
    idle_inputs();
    step();

    // Zero load held off by enable_writeback for two cycles.
    do_reset();
    enable_writeback = 1'b0;
    mem_req = 1'b1;  mem_dr = 3'd6;  mem_data = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      step();
      check("disabled_gnt", 32'(obs_mem), 32'd0);
    end
    enable_writeback = 1'b1;
    step();
    check("enabled_gnt", 32'(obs_mem), 32'd1);
    mem_req = 1'b0;
    check("zero_psr", 32'(psr), 32'b010);
    step();

    // Grant during reset produces no write.
    exe_req = 1'b1;  exe_dr = 3'd1;  exe_data = 16'h0007;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exe_req = 1'b0;
    check("rst_grant_we",  32'(rf_we), 32'd0);
    check("rst_grant_psr", 32'(psr),   32'd0);
    step();

    // Random traffic: requests are held stable until granted.
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      reset            = ($urandom_range(0, 49) == 0);
      enable_writeback = ($urandom_range(0, 7) != 0);
      if (!exe_req && $urandom_range(0, 1) == 1) begin
        exe_req = 1'b1;  exe_dr = 3'($urandom_range(0, 7));  exe_data = rand_data();
      end
      if (!mem_req && $urandom_range(0, 2) != 0) begin
        mem_req = 1'b1;  mem_dr = 3'($urandom_range(0, 7));  mem_data = rand_data();
      end
      step();
      if (obs_exe) exe_req = 1'b0;
      if (obs_mem) mem_req = 1'b0;
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
